ecc_160_enc_wr_pipe: RTL and testbench

Write-side SECDED encoder for 160-bit FIFO entries. It is the counterpart of the read-side lockstep decoder. Two `ecc_160_cal` instances encode each accepted word in lockstep, and their parity results are compared to flag encoder faults. The block sits between the FIFO write port and the RAM and registers each word with valid/ready handshakes on both sides. Its 9-bit parity round-trips through the read-side decoder with `sbit_err = dbit_err = 0`.

---
 rtl/ecc_160_enc_wr_pipe.sv | 101 ++++++++++
 tb/tb_ecc_160_enc_wr_pipe.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ecc_160_enc_wr_pipe.sv
// ecc_160_enc_wr_pipe: two-stage write-side SECDED encoder with lockstep encoder compare.
// ecc_160_cal computes Hamming bits over data positions that skip powers of two, plus an overall parity bit.
module ecc_160_cal #(
   parameter int DATA_WIDTH   = 160,
   parameter int PARITY_WIDTH = 9
) (
   input  logic [DATA_WIDTH-1:0]   data_in,
   input  logic [PARITY_WIDTH-1:0] parity_in,
   input  logic                    bypass,
   output logic [PARITY_WIDTH-1:0] parity_out
);
   localparam int HW = PARITY_WIDTH - 1;
   function automatic int pos_of(input int j);
      int c;
      c = -1;
      for (int p = 1; p < (1 << HW); p++)
         if ((p & (p - 1)) != 0) begin
            c++;
            if (c == j) return p;
         end
      return 0;
   endfunction
   logic [HW-1:0] ham;
   always_comb begin
      ham = '0;
      for (int j = 0; j < DATA_WIDTH; j++)
         if (data_in[j]) ham = ham ^ HW'(pos_of(j));
      parity_out = bypass ? parity_in : {^data_in ^ ^ham, ham};
   end
endmodule

module ecc_160_enc_wr_pipe #(
   parameter int DATA_WIDTH   = 160,
   parameter int PARITY_WIDTH = 9,
   parameter int CNT_WIDTH    = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_vld,
   output logic                    in_rdy,
   input  logic [DATA_WIDTH-1:0]   data_in,
   input  logic                    bypass,
   input  logic                    ecc_fault_detc_en,
   input  logic                    fault_inj,
   output logic                    out_vld,
   input  logic                    out_rdy,
   output logic [DATA_WIDTH-1:0]   data_out,
   output logic [PARITY_WIDTH-1:0] parity_out,
   output logic                    ecc_fault,
   output logic                    fault_sticky,
   input  logic                    fault_clr,
   output logic [CNT_WIDTH-1:0]    fault_cnt
);
   logic                    s1_vld, s1_byp, s1_inj;
   logic [DATA_WIDTH-1:0]   s1_data;
   logic [PARITY_WIDTH-1:0] p0, p1;
   logic                    s1_adv, s2_adv, mis;
   ecc_160_cal #(.DATA_WIDTH(DATA_WIDTH), .PARITY_WIDTH(PARITY_WIDTH)) u_cal0 (
      .data_in(s1_data), .parity_in('0), .bypass(s1_byp), .parity_out(p0));
   ecc_160_cal #(.DATA_WIDTH(DATA_WIDTH), .PARITY_WIDTH(PARITY_WIDTH)) u_cal1 (
      .data_in(s1_data), .parity_in('0), .bypass(s1_byp), .parity_out(p1));
   assign s2_adv = ~out_vld | out_rdy;
   assign s1_adv = s1_vld & s2_adv;
   assign in_rdy = ~s1_vld | s2_adv;
   // fault_inj corrupts only copy 1 so the compare, not the data path, sees it
   assign mis = (p0 != (p1 ^ {{(PARITY_WIDTH-1){1'b0}}, s1_inj})) & ecc_fault_detc_en & ~s1_byp;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vld       <= 1'b0;
         s1_data      <= '0;
         s1_byp       <= 1'b0;
         s1_inj       <= 1'b0;
         out_vld      <= 1'b0;
         data_out     <= '0;
         parity_out   <= '0;
         ecc_fault    <= 1'b0;
         fault_sticky <= 1'b0;
         fault_cnt    <= '0;
      end else begin
         if (in_rdy) s1_vld <= in_vld;
         if (in_vld & in_rdy) begin
            s1_data <= data_in;
            s1_byp  <= bypass;
            s1_inj  <= fault_inj;
         end
         if (s2_adv) out_vld <= s1_vld;
         if (s1_adv) begin
            data_out   <= s1_data;
            parity_out <= s1_byp ? '0 : p0;
            ecc_fault  <= mis;
         end
         if (s1_adv & mis) begin
            fault_sticky <= 1'b1;
            fault_cnt    <= fault_clr ? CNT_WIDTH'(1) : (&fault_cnt ? fault_cnt : fault_cnt + 1'b1);
         end else if (fault_clr) begin
            fault_sticky <= 1'b0;
            fault_cnt    <= '0;
         end
      end
   end
endmodule

// File: tb/tb_ecc_160_enc_wr_pipe.sv
// tb_ecc_160_enc_wr_pipe: directed checks of the write-side encoder pipe.
module tb_ecc_160_enc_wr_pipe;
   logic         clk = 1'b0, rst = 1'b1;
   logic         in_vld = 1'b0, in_rdy, bypass = 1'b0, ecc_fault_detc_en = 1'b0, fault_inj = 1'b0;
   logic         out_vld, out_rdy = 1'b1, ecc_fault, fault_sticky, fault_clr = 1'b0;
   logic [159:0] data_in = '0, data_out;
   logic [8:0]   parity_out;
   logic [7:0]   fault_cnt;
   int           n_chk = 0, n_fail = 0;

   ecc_160_enc_wr_pipe dut (
      .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .data_in(data_in),
      .bypass(bypass), .ecc_fault_detc_en(ecc_fault_detc_en), .fault_inj(fault_inj),
      .out_vld(out_vld), .out_rdy(out_rdy), .data_out(data_out), .parity_out(parity_out),
      .ecc_fault(ecc_fault), .fault_sticky(fault_sticky), .fault_clr(fault_clr), .fault_cnt(fault_cnt));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // read-side view: syndrome and overall parity must both be clean
   function automatic bit dec_ok(input logic [159:0] d, input logic [8:0] p);
      logic [7:0] syn;
      int j;
      j = 0;
      syn = p[7:0];
      for (int pos = 1; j < 160; pos++)
         if ((pos & (pos - 1)) != 0) begin
            if (d[j]) syn = syn ^ pos[7:0];
            j++;
         end
      return (syn == 8'h0) && ((^d ^ ^p) == 1'b0);
   endfunction

   task automatic test_reset();
      rst = 1'b0;
      ecc_fault_detc_en = 1'b1; fault_inj = 1'b1; in_vld = 1'b1; data_in = 160'h5;
      tick();
      in_vld = 1'b0; fault_inj = 1'b0;
      tick();
      #2 rst = 1'b1;
      #1;
      n_chk++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL reset_out_vld got %b want 0", out_vld); end
      n_chk++; if (data_out !== 160'h0 || parity_out !== 9'h0) begin n_fail++; $display("FAIL reset_data got %h/%h want 0/0", data_out, parity_out); end
      n_chk++; if ({ecc_fault, fault_sticky, fault_cnt} !== 10'h0) begin n_fail++; $display("FAIL reset_fault got %b%b%h want 0", ecc_fault, fault_sticky, fault_cnt); end
      tick();
      rst = 1'b0; ecc_fault_detc_en = 1'b0;
      #1;
      n_chk++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_in_rdy got %b want 1", in_rdy); end
   endtask

   task automatic test_single();
      out_rdy = 1'b1; in_vld = 1'b1; data_in = 160'h1;
      tick();
      in_vld = 1'b0;
      n_chk++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL single_early got %b want 0", out_vld); end
      tick();
      n_chk++; if (out_vld !== 1'b1 || data_out !== 160'h1) begin n_fail++; $display("FAIL single_out got %b/%h want 1/1", out_vld, data_out); end
      n_chk++; if (parity_out !== 9'h103) begin n_fail++; $display("FAIL single_par got %h want 103", parity_out); end
      n_chk++; if (!dec_ok(data_out, parity_out)) begin n_fail++; $display("FAIL single_decode got err want clean"); end
      tick();
      n_chk++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL single_drain got %b want 0", out_vld); end
   endtask

   task automatic test_back_to_back();
      logic [159:0] d [3] = '{160'hA, 160'hB, 160'hC};
      logic [8:0]   p [3] = '{9'h102, 9'h001, 9'h101};
      out_rdy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_vld = (i < 3);
         data_in = (i < 3) ? d[i] : '0;
         tick();
         if (i >= 1 && i <= 3) begin
            n_chk++;
            if (out_vld !== 1'b1 || data_out !== d[i-1] || parity_out !== p[i-1]) begin
               n_fail++; $display("FAIL b2b_%0d got %b/%h/%h want 1/%h/%h", i-1, out_vld, data_out, parity_out, d[i-1], p[i-1]);
            end
         end
      end
      in_vld = 1'b0;
   endtask

   task automatic test_backpressure();
      out_rdy = 1'b0; in_vld = 1'b1; data_in = 160'hA;
      tick();
      n_chk++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL bp_rdy1 got %b want 1", in_rdy); end
      data_in = 160'hB;
      tick();
      n_chk++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL bp_rdy2 got %b want 0", in_rdy); end
      data_in = 160'hC;
      tick();
      tick();
      n_chk++; if (out_vld !== 1'b1 || data_out !== 160'hA || parity_out !== 9'h102) begin n_fail++; $display("FAIL bp_hold got %b/%h/%h want 1/a/102", out_vld, data_out, parity_out); end
      out_rdy = 1'b1;
      #1;
      n_chk++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL bp_rdy_comb got %b want 1", in_rdy); end
      tick();
      in_vld = 1'b0;
      n_chk++; if (out_vld !== 1'b1 || data_out !== 160'hB) begin n_fail++; $display("FAIL bp_b got %b/%h want 1/b", out_vld, data_out); end
      tick();
      n_chk++; if (out_vld !== 1'b1 || data_out !== 160'hC || parity_out !== 9'h101) begin n_fail++; $display("FAIL bp_c got %b/%h/%h want 1/c/101", out_vld, data_out, parity_out); end
      tick();
      n_chk++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL bp_drain got %b want 0", out_vld); end
   endtask

   task automatic test_fault_inj();
      out_rdy = 1'b1; ecc_fault_detc_en = 1'b1; fault_inj = 1'b1; in_vld = 1'b1; data_in = 160'hFF;
      tick();
      in_vld = 1'b0; fault_inj = 1'b0;
      tick();
      n_chk++; if (ecc_fault !== 1'b1 || parity_out !== 9'h003 || data_out !== 160'hFF) begin n_fail++; $display("FAIL inj_beat got %b/%h/%h want 1/003/ff", ecc_fault, parity_out, data_out); end
      n_chk++; if (fault_sticky !== 1'b1 || fault_cnt !== 8'd1) begin n_fail++; $display("FAIL inj_cnt got %b/%0d want 1/1", fault_sticky, fault_cnt); end
      ecc_fault_detc_en = 1'b0; fault_inj = 1'b1; in_vld = 1'b1;
      tick();
      in_vld = 1'b0; fault_inj = 1'b0;
      tick();
      n_chk++; if (ecc_fault !== 1'b0 || fault_cnt !== 8'd1) begin n_fail++; $display("FAIL inj_disabled got %b/%0d want 0/1", ecc_fault, fault_cnt); end
      // enable raised only after accept still catches the fault at the S1->S2 edge
      fault_inj = 1'b1; in_vld = 1'b1;
      tick();
      in_vld = 1'b0; fault_inj = 1'b0; ecc_fault_detc_en = 1'b1;
      tick();
      n_chk++; if (ecc_fault !== 1'b1 || fault_cnt !== 8'd2) begin n_fail++; $display("FAIL inj_late_en got %b/%0d want 1/2", ecc_fault, fault_cnt); end
   endtask

   task automatic test_bypass();
      bypass = 1'b1; fault_inj = 1'b1; in_vld = 1'b1; data_in = 160'hFF;
      tick();
      in_vld = 1'b0; fault_inj = 1'b0; bypass = 1'b0;
      tick();
      n_chk++; if (out_vld !== 1'b1 || parity_out !== 9'h0 || ecc_fault !== 1'b0) begin n_fail++; $display("FAIL bypass got %b/%h/%b want 1/000/0", out_vld, parity_out, ecc_fault); end
      n_chk++; if (fault_cnt !== 8'd2) begin n_fail++; $display("FAIL bypass_cnt got %0d want 2", fault_cnt); end
   endtask

   task automatic test_clear_sat();
      fault_inj = 1'b1; in_vld = 1'b1; data_in = 160'h3C;
      tick();
      in_vld = 1'b0; fault_inj = 1'b0; fault_clr = 1'b1;
      tick();
      fault_clr = 1'b0;
      n_chk++; if (fault_sticky !== 1'b1 || fault_cnt !== 8'd1) begin n_fail++; $display("FAIL clr_same_cycle got %b/%0d want 1/1", fault_sticky, fault_cnt); end
      fault_clr = 1'b1;
      tick();
      fault_clr = 1'b0;
      n_chk++; if (fault_sticky !== 1'b0 || fault_cnt !== 8'd0) begin n_fail++; $display("FAIL clr_alone got %b/%0d want 0/0", fault_sticky, fault_cnt); end
      fault_inj = 1'b1; in_vld = 1'b1;
      for (int i = 0; i < 300; i++) begin
         data_in = 160'(i + 1);
         tick();
         if (i == 255) begin
            n_chk++; if (fault_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_reach got %0d want 255", fault_cnt); end
         end
      end
      in_vld = 1'b0; fault_inj = 1'b0;
      tick();
      tick();
      n_chk++; if (fault_cnt !== 8'd255 || fault_sticky !== 1'b1) begin n_fail++; $display("FAIL sat_hold got %0d/%b want 255/1", fault_cnt, fault_sticky); end
   endtask

   initial begin
      tick();
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_fault_inj();
      test_bypass();
      test_clear_sat();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
